// File: rtl/mux_seq_pkg.sv
// Shared state encoding, sizes and the reference 2:1 mux function for the
// mux pattern sequencer.
package mux_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int NUM_PATTERNS = 8;
    localparam int ERR_W        = 4;

    // Golden behaviour of the mux under test: s picks i1, otherwise i0.
    function automatic logic mux_ref(input logic i0, input logic i1, input logic s);
        return s ? i1 : i0;
    endfunction

endpackage

// File: rtl/mux_hold_timer.sv
// Hold-window timer: counts while enabled and raises tick on the last cycle
// of every HOLD_CYCLES-long window; clr holds the count at zero.
module mux_hold_timer #(
    parameter int HOLD_CYCLES = 20,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_pattern_sequencer.sv
// Self-test sequencer for a 2:1 mux: walks {i0,i1,s} through all 8 patterns,
// checks y on the last cycle of each hold window and reports pass/err_cnt.
// Optional first-failure capture is enabled with `define MUXSEQ_FIRST_FAIL_EN.
module mux_pattern_sequencer
    import mux_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 20,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             y,
    output logic             i0,
    output logic             i1,
    output logic             s,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
`ifdef MUXSEQ_FIRST_FAIL_EN
    ,
    output logic             first_fail_vld,
    output logic [2:0]       first_fail_idx
`endif
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_PATTERNS - 1);

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             tick;
    logic             mismatch;
`ifdef MUXSEQ_FIRST_FAIL_EN
    logic             ff_vld_q, ff_vld_d;
    logic [2:0]       ff_idx_q, ff_idx_d;
`endif

    mux_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state_q != DRIVE),
        .tick (tick)
    );

    // idx doubles as the driven pattern, so i0/i1/s stay at 111 after a run.
    assign {i0, i1, s} = idx_q;
    assign mismatch    = (y != mux_ref(idx_q[2], idx_q[1], idx_q[0]));
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_cnt     = err_q;
`ifdef MUXSEQ_FIRST_FAIL_EN
    assign first_fail_vld = ff_vld_q;
    assign first_fail_idx = ff_idx_q;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
`ifdef MUXSEQ_FIRST_FAIL_EN
        ff_vld_d = ff_vld_q;
        ff_idx_d = ff_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
`ifdef MUXSEQ_FIRST_FAIL_EN
                    ff_vld_d = 1'b0;
                    ff_idx_d = '0;
`endif
                end
            end
            DRIVE: begin
                if (tick) begin
                    if (mismatch) begin
                        err_d = err_q + ERR_W'(1);
`ifdef MUXSEQ_FIRST_FAIL_EN
                        if (!ff_vld_q) begin
                            ff_vld_d = 1'b1;
                            ff_idx_d = idx_q;
                        end
`endif
                    end
                    if (idx_q == LAST_IDX) begin
                        // The verdict includes the compare made on this edge.
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
`ifdef MUXSEQ_FIRST_FAIL_EN
            ff_vld_q <= 1'b0;
            ff_idx_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
`ifdef MUXSEQ_FIRST_FAIL_EN
            ff_vld_q <= ff_vld_d;
            ff_idx_q <= ff_idx_d;
`endif
        end
    end

endmodule

// File: tb/tb_mux_pattern_sequencer.sv
// Bench for mux_pattern_sequencer: a behavioural 2:1 mux (good or faulty)
// closes the y loop; run results are queued at start and checked on done.
module tb_mux_pattern_sequencer;

    typedef struct {
        int err;
        int pass;
        int ff_vld;
        int ff_idx;
        int blen;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start_b;
    logic       y, y_b;
    logic       i0, i1, s, busy, done, pass;
    logic [3:0] err_cnt;
    logic       i0_b, i1_b, s_b, busy_b, done_b, pass_b;
    logic [3:0] err_cnt_b;
`ifdef MUXSEQ_FIRST_FAIL_EN
    logic       ff_vld, ff_vld_b;
    logic [2:0] ff_idx, ff_idx_b;
`endif

    int   fmode = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   bcnt_a = 0;
    int   bcnt_b = 0;

    always #5 clk = ~clk;

    mux_pattern_sequencer #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .y(y),
        .i0(i0), .i1(i1), .s(s), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt)
`ifdef MUXSEQ_FIRST_FAIL_EN
        , .first_fail_vld(ff_vld), .first_fail_idx(ff_idx)
`endif
    );

    mux_pattern_sequencer #(.HOLD_CYCLES(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .y(y_b),
        .i0(i0_b), .i1(i1_b), .s(s_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_cnt_b)
`ifdef MUXSEQ_FIRST_FAIL_EN
        , .first_fail_vld(ff_vld_b), .first_fail_idx(ff_idx_b)
`endif
    );

    // Mux under test: 0 good, 1 stuck select (y=i0), 2 inverted output.
    always_comb begin
        case (fmode)
            0:       y = s ? i1 : i0;
            1:       y = i0;
            default: y = ~(s ? i1 : i0);
        endcase
    end
    assign y_b = s_b ? i1_b : i0_b;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Monitor for the HOLD_CYCLES=4 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            bcnt_a = 0;
        end else begin
            if (busy) begin
                check("a_pattern", int'({i0, i1, s}), bcnt_a / 4);
                bcnt_a++;
            end
            if (done) begin
                if (qa.size() == 0) begin
                    check("a_spurious_done", 1, 0);
                end else begin
                    ea = qa.pop_front();
                    check("a_busy_len", bcnt_a, ea.blen);
                    check("a_err_cnt", int'(err_cnt), ea.err);
                    check("a_pass", int'(pass), ea.pass);
                    check("a_busy_at_done", int'(busy), 0);
                    check("a_pattern_at_done", int'({i0, i1, s}), 7);
`ifdef MUXSEQ_FIRST_FAIL_EN
                    check("a_ff_vld", int'(ff_vld), ea.ff_vld);
                    if (ea.ff_vld != 0) check("a_ff_idx", int'(ff_idx), ea.ff_idx);
`endif
                end
                bcnt_a = 0;
            end
        end
    end

    // Monitor for the HOLD_CYCLES=2 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            bcnt_b = 0;
        end else begin
            if (busy_b) begin
                check("b_pattern", int'({i0_b, i1_b, s_b}), bcnt_b / 2);
                bcnt_b++;
            end
            if (done_b) begin
                if (qb.size() == 0) begin
                    check("b_spurious_done", 1, 0);
                end else begin
                    eb = qb.pop_front();
                    check("b_busy_len", bcnt_b, eb.blen);
                    check("b_err_cnt", int'(err_cnt_b), eb.err);
                    check("b_pass", int'(pass_b), eb.pass);
                end
                bcnt_b = 0;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) check(nm, 0, 1);
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_pattern"}, int'({i0, i1, s}), 0);
        check({nm, "_busy"}, int'(busy), 0);
        check({nm, "_done"}, int'(done), 0);
        check({nm, "_pass"}, int'(pass), 0);
        check({nm, "_err_cnt"}, int'(err_cnt), 0);
`ifdef MUXSEQ_FIRST_FAIL_EN
        check({nm, "_ff"}, int'({ff_vld, ff_idx}), 0);
`endif
    endtask

    initial begin
        bit seen;
        rst_n   = 1'b0;
        start   = 1'b0;
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_b_outs", int'({i0_b, i1_b, s_b, busy_b, done_b, pass_b, err_cnt_b}), 0);
        rst_n = 1'b1;

        // Good mux: 32 busy cycles, pass.
        fmode = 0;
        qa.push_back('{err: 0, pass: 1, ff_vld: 0, ff_idx: 0, blen: 32});
        pulse_start();
        check("good_busy_rise", int'(busy), 1);
        wait_done_a(60, "good_timeout");

        // Stuck select: patterns 011 and 101 mismatch.
        fmode = 1;
        qa.push_back('{err: 2, pass: 0, ff_vld: 1, ff_idx: 3, blen: 32});
        pulse_start();
        wait_done_a(60, "stuck_timeout");

        // Inverted output: every compare mismatches.
        fmode = 2;
        qa.push_back('{err: 8, pass: 0, ff_vld: 1, ff_idx: 0, blen: 32});
        pulse_start();
        wait_done_a(60, "inv_timeout");

        // start held high: one run to DONE, then a fresh run once back in IDLE.
        fmode = 2;
        qa.push_back('{err: 8, pass: 0, ff_vld: 1, ff_idx: 0, blen: 32});
        qa.push_back('{err: 0, pass: 1, ff_vld: 0, ff_idx: 0, blen: 32});
        @(negedge clk) start = 1'b1;
        wait_done_a(60, "held1_timeout");
        fmode = 0;
        @(negedge clk);
        check("held_idle_gap_busy", int'(busy), 0);
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check("held_restart", int'(seen), 1);
        check("held_err_cleared", int'(err_cnt), 0);
`ifdef MUXSEQ_FIRST_FAIL_EN
        check("held_ff_cleared", int'(ff_vld), 0);
`endif
        start = 1'b0;
        wait_done_a(60, "held2_timeout");

        // Reset mid-run at pattern 011: immediate abort, no done.
        fmode = 0;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if ({i0, i1, s} == 3'd3) seen = 1'b1;
        end
        check("midrun_reach_idx3", int'(seen), 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrun_rst");
        repeat (3) @(negedge clk);
        check_idle_outputs("midrun_hold");
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midrun_no_restart", int'(busy), 0);

        // HOLD_CYCLES=2 corner: 16 busy cycles, pass.
        qb.push_back('{err: 0, pass: 1, ff_vld: 0, ff_idx: 0, blen: 16});
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done_b) seen = 1'b1;
        end
        if (!seen) check("b_timeout", 0, 1);
        @(negedge clk);

        check("queues_drained", qa.size() + qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
